// File: rtl/mbist_burst_host.sv
// ---------------------------------------------------------------------------
// mbist_burst_host
//
// Wishbone burst master for the MBIST burst slave. The slave exposes an SRAM
// window and an MBIST register window. Each accepted command becomes exactly
// one burst. Write beats come from an internal write FIFO, and read beats are
// collected in an internal read FIFO. Beat flow uses the slave's burst-ready
// (wb_bry_o) and last-ack (wb_lack_i) handshake. A command that the slave
// cannot serve is rejected before any wishbone activity starts.
//
// Ports
//   wb_clk_i, rst_n        clock, asynchronous active-low reset
//   cmd_*                  command request (valid/ready, addr, we, bl, sel)
//   wdata_valid/wdata      write FIFO push; wdata_ready = FIFO can accept
//   rdata_valid/rdata      read FIFO head; rdata_ready pops it
//   done                   one-cycle pulse when a burst completes
//   err, err_code          one-cycle reject/abort pulse and its cause
//                          (1 bad length, 2 SRAM boundary, 3 slave error)
//   wb_*_o                 wishbone master request toward the slave
//   wb_dat_i, wb_ack_i,
//   wb_lack_i, wb_err_i    slave response
// ---------------------------------------------------------------------------
module mbist_burst_host #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [14:0] cmd_addr,
    input  logic        cmd_we,
    input  logic [9:0]  cmd_bl,
    input  logic [3:0]  cmd_sel,
    input  logic        wdata_valid,
    input  logic [31:0] wdata,
    output logic        wdata_ready,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    input  logic        rdata_ready,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [14:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [9:0]  wb_bl_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_bry_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_lack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [FIFO_AW:0]   DEPTH_C   = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   ONE_C     = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   TWO_C     = (FIFO_AW + 1)'(2);
    localparam logic [FIFO_AW-1:0] PTR_ONE_C = FIFO_AW'(1);

    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_BOUND = 2'd2;
    localparam logic [1:0] ERR_SLAVE = 2'd3;

    // Control state
    state_e      state_q, state_d;
    logic [9:0]  beat_cnt_q, beat_cnt_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [14:0] adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [9:0]  bl_q, bl_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    // Write FIFO
    logic [31:0]        wmem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wwp_q, wwp_d, wrp_q, wrp_d;
    logic [FIFO_AW:0]   wcnt_q, wcnt_d;

    // Read FIFO
    logic [31:0]        rmem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rwp_q, rwp_d, rrp_q, rrp_d;
    logic [FIFO_AW:0]   rcnt_q, rcnt_d;

    logic        is_reg;
    logic [10:0] end_word;
    logic        bad_len;
    logic        bad_bound;
    logic        beat_live;
    logic        w_push, w_pop, r_push, r_pop;

    // Command screening. The end word is formed in 11 bits so a burst that
    // runs past word 511 shows up as a value above 511 instead of wrapping.
    assign is_reg    = (cmd_addr[14:12] == 3'd0);
    assign end_word  = {2'b00, cmd_addr[10:2]} + {1'b0, cmd_bl} - 11'd1;
    assign bad_len   = (cmd_bl == 10'd0) || (is_reg && (cmd_bl != 10'd1));
    assign bad_bound = !is_reg && (end_word > 11'd511);

    // A beat only counts while beats are still owed; stray acks are dropped.
    assign beat_live = (state_q == ST_BURST) && wb_ack_i && !wb_err_i
                       && (beat_cnt_q != 10'd0);

    assign w_push = wdata_valid && wdata_ready;
    assign w_pop  = beat_live && we_q && (wcnt_q != '0);
    assign r_push = beat_live && !we_q && (rcnt_q != DEPTH_C);
    assign r_pop  = rdata_ready && (rcnt_q != '0);

    always_comb begin
        // NOTE: every _d signal takes its hold value first, so no branch of the
        // case below can leave one unassigned and infer a latch.
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        stb_d      = stb_q;
        we_d       = we_q;
        adr_d      = adr_q;
        sel_d      = sel_q;
        bl_d       = bl_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        wwp_d  = w_push ? wwp_q + PTR_ONE_C : wwp_q;
        wrp_d  = w_pop  ? wrp_q + PTR_ONE_C : wrp_q;
        wcnt_d = wcnt_q + (w_push ? ONE_C : '0) - (w_pop ? ONE_C : '0);
        rwp_d  = r_push ? rwp_q + PTR_ONE_C : rwp_q;
        rrp_d  = r_pop  ? rrp_q + PTR_ONE_C : rrp_q;
        rcnt_d = rcnt_q + (r_push ? ONE_C : '0) - (r_pop ? ONE_C : '0);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (bad_len) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                    end else if (bad_bound) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BOUND;
                    end else begin
                        adr_d      = cmd_addr;
                        we_d       = cmd_we;
                        sel_d      = cmd_sel;
                        bl_d       = cmd_bl;
                        beat_cnt_d = cmd_bl;
                        stb_d      = 1'b1;
                        state_d    = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (wb_err_i) begin
                    stb_d      = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = ERR_SLAVE;
                    state_d    = ST_FLUSH;
                end else begin
                    if (beat_live) begin
                        beat_cnt_d = beat_cnt_q - 10'd1;
                    end
                    if (wb_lack_i) begin
                        stb_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                // Discard whatever write data the aborted burst left behind;
                // read data already collected stays available.
                wwp_d   = '0;
                wrp_d   = '0;
                wcnt_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment, so every flop
    // samples its _d value from the same pre-edge snapshot.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            sel_q      <= '0;
            bl_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            wwp_q      <= '0;
            wrp_q      <= '0;
            wcnt_q     <= '0;
            rwp_q      <= '0;
            rrp_q      <= '0;
            rcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            sel_q      <= sel_d;
            bl_q       <= bl_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            wwp_q      <= wwp_d;
            wrp_q      <= wrp_d;
            wcnt_q     <= wcnt_d;
            rwp_q      <= rwp_d;
            rrp_q      <= rrp_d;
            rcnt_q     <= rcnt_d;
        end
    end

    // NOTE: FIFO storage has no reset; the occupancy counters define which
    // entries are valid, and the data outputs read as 0 while a FIFO is empty.
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            wmem[wwp_q] <= wdata;
        end
        if (r_push) begin
            rmem[rwp_q] <= wb_dat_i;
        end
    end

    // Burst-ready. For writes the last beat may go with a single word queued.
    // For reads two free slots are required, because one ack can already be
    // in flight when bry is sampled.
    always_comb begin
        wb_bry_o = 1'b0;
        if (state_q == ST_BURST) begin
            if (we_q) begin
                wb_bry_o = (wcnt_q >= TWO_C)
                           || ((wcnt_q >= ONE_C) && (beat_cnt_q == 10'd1));
            end else begin
                wb_bry_o = ((DEPTH_C - rcnt_q) >= TWO_C);
            end
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign wdata_ready = (state_q != ST_FLUSH) && (wcnt_q != DEPTH_C);
    assign rdata_valid = (rcnt_q != '0);
    assign rdata       = (rcnt_q != '0) ? rmem[rrp_q] : '0;
    assign wb_dat_o    = (wcnt_q != '0) ? wmem[wrp_q] : '0;

    assign wb_stb_o = stb_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_sel_o = sel_q;
    assign wb_bl_o  = bl_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_mbist_burst_host.sv
// ---------------------------------------------------------------------------
// tb_mbist_burst_host
//
// Self-checking bench for mbist_burst_host. A behavioural slave answers the
// bursts with random stalls. Queues model the data FIFOs: each holds the
// words the host must currently be holding, in order. A rule-level function
// predicts whether each command is accepted and, if not, which error code it
// gets. Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mbist_burst_host;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [14:0] cmd_addr;
    logic        cmd_we;
    logic [9:0]  cmd_bl;
    logic [3:0]  cmd_sel;
    logic        wdata_valid;
    logic [31:0] wdata;
    logic        wdata_ready;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        rdata_ready;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [14:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [9:0]  wb_bl_o;
    logic [31:0] wb_dat_o;
    logic        wb_bry_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_lack_i;
    logic        wb_err_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the FIFO contents the host should be holding.
    logic [31:0] wq[$];
    logic [31:0] rq[$];

    mbist_burst_host #(
        .FIFO_DEPTH (DEPTH),
        .FIFO_AW    (3)
    ) dut (
        .wb_clk_i    (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_we      (cmd_we),
        .cmd_bl      (cmd_bl),
        .cmd_sel     (cmd_sel),
        .wdata_valid (wdata_valid),
        .wdata       (wdata),
        .wdata_ready (wdata_ready),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .rdata_ready (rdata_ready),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_sel_o    (wb_sel_o),
        .wb_bl_o     (wb_bl_o),
        .wb_dat_o    (wb_dat_o),
        .wb_bry_o    (wb_bry_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_lack_i   (wb_lack_i),
        .wb_err_i    (wb_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outcome of a command: 0 accepted, otherwise the error code.
    function automatic int exp_code(input int addr, input int bl);
        int word;
        if (bl == 0) return 1;
        if ((addr >> 12) == 0) return (bl == 1) ? 0 : 1;
        word = (addr >> 2) % 512;
        if (word + bl - 1 > 511) return 2;
        return 0;
    endfunction

    task automatic push_word(input logic [31:0] v);
        check("wready_idle", wdata_ready, 1);
        wdata_valid = 1'b1;
        wdata       = v;
        wq.push_back(v);
        @(negedge clk);
        wdata_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [14:0] addr, input bit we, input int bl,
                            input logic [3:0] sel, output bit accepted);
        int code;
        code = exp_code(int'(addr), bl);
        check("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_we    = we;
        cmd_bl    = 10'(bl);
        cmd_sel   = sel;
        @(negedge clk);
        cmd_valid = 1'b0;
        accepted  = (code == 0);
        check("stb_t1", wb_stb_o, accepted);
        check("err_t1", err, !accepted);
        if (accepted) begin
            check("adr_latch", wb_adr_o, addr);
            check("we_latch", wb_we_o, we);
            check("bl_latch", wb_bl_o, bl);
            check("sel_latch", wb_sel_o, sel);
        end else begin
            check("err_code", err_code, code);
            @(negedge clk);
            check("err_pulse", err, 0);
            check("rej_no_stb", wb_stb_o, 0);
            check("rej_idle", cmd_ready, 1);
        end
    endtask

    // Slave side of one burst. The slave acks only while bry is high, adds
    // random stalls, may inject an error in place of beat err_at, and feeds
    // write data and drains read data while the burst runs.
    task automatic run_burst(input bit we, input int bl, input int feed, input int feed_after,
                             input int err_at, input int ready_after, input bit rnd_ready);
        int          beats = 0;
        int          cyc   = 0;
        int          wsize0;
        int          feed_left;
        bit          fin = 0;
        bit          lack_sent;
        bit          err_sent;
        bit          exp_bry;
        logic [31:0] w;
        feed_left = feed;
        while (!fin) begin
            lack_sent = 0;
            err_sent  = 0;
            wsize0    = wq.size();
            if (we) exp_bry = (wsize0 >= 2) || (wsize0 >= 1 && (bl - beats) == 1);
            else    exp_bry = (DEPTH - rq.size()) >= 2;
            check("bry", wb_bry_o, exp_bry);
            check("stb_hold", wb_stb_o, 1);
            check("rvalid", rdata_valid, rq.size() != 0);

            rdata_ready = (cyc >= ready_after) && (!rnd_ready || $urandom_range(0, 1) == 1);
            if (rdata_ready && rq.size() != 0) begin
                w = rq.pop_front();
                check("rdata", rdata, w);
            end

            if (wb_stb_o && wb_bry_o && $urandom_range(0, 3) != 0) begin
                if (beats == err_at) begin
                    wb_err_i = 1'b1;
                    err_sent = 1;
                end else begin
                    wb_ack_i  = 1'b1;
                    lack_sent = (beats == bl - 1);
                    wb_lack_i = lack_sent;
                    if (we) begin
                        if (wq.size() != 0) begin
                            w = wq.pop_front();
                            check("wb_dat", wb_dat_o, w);
                        end
                    end else begin
                        w        = $urandom;
                        wb_dat_i = w;
                        rq.push_back(w);
                    end
                    beats++;
                end
            end

            if (we && !err_sent && feed_left > 0 && cyc >= feed_after && wsize0 < DEPTH
                && $urandom_range(0, 1) == 1) begin
                check("wready_burst", wdata_ready, 1);
                w           = $urandom;
                wdata_valid = 1'b1;
                wdata       = w;
                wq.push_back(w);
                feed_left--;
            end

            @(negedge clk);
            wb_ack_i    = 1'b0;
            wb_lack_i   = 1'b0;
            wb_err_i    = 1'b0;
            wdata_valid = 1'b0;
            rdata_ready = 1'b0;
            cyc++;

            if (lack_sent) begin
                check("done", done, 1);
                check("stb_drop", wb_stb_o, 0);
                check("bry_drop", wb_bry_o, 0);
                check("ready_back", cmd_ready, 1);
                @(negedge clk);
                check("done_once", done, 0);
                fin = 1;
            end else if (err_sent) begin
                check("err_slave", err, 1);
                check("err_code3", err_code, 3);
                check("stb_err", wb_stb_o, 0);
                check("flush_wready", wdata_ready, 0);
                check("flush_busy", cmd_ready, 0);
                wq.delete();
                @(negedge clk);
                check("idle_after_flush", cmd_ready, 1);
                check("err_once", err, 0);
                fin = 1;
            end else begin
                check("no_done", done, 0);
                check("no_err", err, 0);
                if (cyc > 2000) begin
                    check("burst_timeout", cyc, 0);
                    fin = 1;
                end
            end
        end
    endtask

    task automatic drain();
        int          guard = 0;
        logic [31:0] w;
        while (rq.size() != 0 && guard < 64) begin
            check("drain_valid", rdata_valid, 1);
            w = rq.pop_front();
            check("drain_data", rdata, w);
            rdata_ready = 1'b1;
            @(negedge clk);
            rdata_ready = 1'b0;
            guard++;
        end
        check("drain_empty", rdata_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expired expected run completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          acc;
        logic [14:0] a;
        int          bl;
        int          code;
        int          pre;
        int          err_at;
        bit          we;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_addr    = '0;
        cmd_we      = 1'b0;
        cmd_bl      = '0;
        cmd_sel     = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        rdata_ready = 1'b0;
        wb_dat_i    = '0;
        wb_ack_i    = 1'b0;
        wb_lack_i   = 1'b0;
        wb_err_i    = 1'b0;

        // Reset values
        #3;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_stb", wb_stb_o, 0);
        check("rst_bry", wb_bry_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_bl", wb_bl_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_err_code", err_code, 0);
        check("rst_rvalid", rdata_valid, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 4-beat write to 0x2000 from a preloaded FIFO
        for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
        send_cmd(15'h2000, 1'b1, 4, 4'hF, acc);
        if (acc) run_burst(1'b1, 4, 0, 0, -1, 0, 1'b0);

        // 8-beat read from 0x3800 with the consumer held off; bry must fall
        // back when fewer than two slots remain
        send_cmd(15'h3800, 1'b0, 8, 4'hF, acc);
        if (acc) run_burst(1'b0, 8, 0, 0, -1, 40, 1'b0);
        drain();

        // Register window: single beat works, two beats are rejected
        push_word(32'h0000_5A5A);
        send_cmd(15'h0004, 1'b1, 1, 4'hF, acc);
        if (acc) run_burst(1'b1, 1, 0, 0, -1, 0, 1'b0);
        send_cmd(15'h0004, 1'b1, 2, 4'hF, acc);

        // SRAM end-of-window boundary
        send_cmd(15'h27FC, 1'b0, 2, 4'hF, acc);
        send_cmd(15'h27FC, 1'b0, 1, 4'hF, acc);
        if (acc) run_burst(1'b0, 1, 0, 0, -1, 0, 1'b1);
        drain();

        // Zero-length command
        send_cmd(15'h1000, 1'b0, 0, 4'hF, acc);

        // Starved 6-beat write, aborted by a slave error after three beats
        push_word(32'hC0C0_0001);
        send_cmd(15'h1100, 1'b1, 6, 4'h3, acc);
        if (acc) run_burst(1'b1, 6, 5, 3, 3, 0, 1'b1);
        // The flush must have emptied the write FIFO: new data comes out first
        push_word(32'hB0);
        push_word(32'hB1);
        send_cmd(15'h1200, 1'b1, 2, 4'hF, acc);
        if (acc) run_burst(1'b1, 2, 0, 0, -1, 0, 1'b0);

        // Asynchronous reset in the middle of a read burst
        send_cmd(15'h1000, 1'b0, 8, 4'hF, acc);
        for (int i = 0; i < 3; i++) begin
            check("pre_rst_bry", wb_bry_o, 1);
            wb_ack_i = 1'b1;
            wb_dat_i = $urandom;
            @(negedge clk);
            wb_ack_i = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_stb", wb_stb_o, 0);
        check("arst_bry", wb_bry_o, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_err_code", err_code, 0);
        check("arst_rvalid", rdata_valid, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_wready", wdata_ready, 1);
        check("arst_adr", wb_adr_o, 0);
        check("arst_bl", wb_bl_o, 0);
        check("arst_we", wb_we_o, 0);
        check("arst_sel", wb_sel_o, 0);
        check("arst_dat", wb_dat_o, 0);
        rq.delete();
        wq.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        push_word(32'hD00D_0001);
        push_word(32'hD00D_0002);
        send_cmd(15'h4010, 1'b1, 2, 4'hC, acc);
        if (acc) run_burst(1'b1, 2, 0, 0, -1, 0, 1'b0);

        // Random commands against the model
        for (int t = 0; t < 30; t++) begin
            a = 15'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                a[14:12] = 3'd0;
                bl       = $urandom_range(0, 2);
            end else begin
                if (a[14:12] == 3'd0) a[14:12] = 3'd5;
                if ($urandom_range(0, 2) == 0) a[10:2] = 9'(511 - $urandom_range(0, 12));
                bl = $urandom_range(0, 14);
            end
            we   = 1'($urandom_range(0, 1));
            code = exp_code(int'(a), bl);
            pre  = 0;
            if (we && code == 0) begin
                pre = $urandom_range(0, DEPTH);
                if (pre > bl) pre = bl;
                for (int i = 0; i < pre; i++) push_word($urandom);
            end
            send_cmd(a, we, bl, 4'($urandom), acc);
            if (acc) begin
                err_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, bl - 1)) : -1;
                run_burst(we, bl, bl - pre, $urandom_range(0, 4), err_at,
                          $urandom_range(0, 10), 1'b1);
                drain();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mbist_burst_host.md
# mbist_burst_host

Wishbone burst master that drives the MBIST wishbone burst slave (SRAM window plus MBIST register window) from a simple command/stream interface. It sits directly upstream of that slave. It issues one burst per accepted command, sources write beats from an internal write FIFO and sinks read beats into an internal read FIFO. Flow control uses the slave's burst-ready (`wb_bry`) and last-ack (`wb_lack`) protocol. It also rejects commands the slave cannot serve.

## Interface
- `FIFO_DEPTH`, default 8: depth of each data FIFO; power of two, at least 4.
- `FIFO_AW`, default 3: log2(`FIFO_DEPTH`).
- `wb_clk_i`  in  1  clock (already decided).
- `rst_n`  in  1  asynchronous, active-low reset (already decided).
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_addr`  in  15  byte address. Bits [14:12]==0 selects the register window; otherwise [12:11] selects the SRAM and [10:2] is the word address.
- `cmd_we`  in  1  1 = write burst, 0 = read burst.
- `cmd_bl`  in  10  burst length in beats.
- `cmd_sel`  in  4  byte enables, applied to every beat.
- `wdata_valid`, `wdata`  in  1/32  write FIFO push.
- `wdata_ready`  out  1  write FIFO not full.
- `rdata_valid`, `rdata`  out  1/32  read FIFO head.
- `rdata_ready`  in  1  pops the read FIFO.
- `done`  out  1  one-cycle pulse at burst completion.
- `err`  out  1  one-cycle pulse when a command is rejected or aborted.
- `err_code`  out  2  valid with `err`: 1 = bad length, 2 = SRAM boundary cross, 3 = slave error. Holds its last value.
- `wb_stb_o`, `wb_we_o`, `wb_adr_o[14:0]`, `wb_sel_o[3:0]`, `wb_bl_o[9:0]`, `wb_dat_o[31:0]`, `wb_bry_o`  out  wishbone master request.
- `wb_dat_i[31:0]`, `wb_ack_i`, `wb_lack_i`, `wb_err_i`  in  slave response.

## Operation
- States: IDLE, BURST, FLUSH.
- `cmd_ready` is high only in IDLE; it is combinational and therefore 1 after reset.
- The command is checked on the accept cycle:
  - `cmd_bl`==0 → reject with code 1.
  - Register window with `cmd_bl`!=1 → reject with code 1.
  - SRAM window with `cmd_addr[10:2]` + `cmd_bl` − 1 > 511 → reject with code 2. Compute in 11 bits with no wrap.
  - A rejected command pulses `err` the next cycle, never asserts `wb_stb_o`, and stays in IDLE.
- A valid command latches `wb_adr_o`, `wb_we_o`, `wb_sel_o` and `wb_bl_o`, loads `beat_cnt` = `cmd_bl`, and moves to BURST with `wb_stb_o`=1. The address is not incremented by this block; the slave increments it.
- Write bursts, in BURST:
  - `wb_dat_o` = write FIFO head.
  - `wb_bry_o` = (write FIFO count ≥ 2) or (count ≥ 1 and `beat_cnt` == 1).
  - Each `wb_ack_i` pops the write FIFO and decrements `beat_cnt`.
- Read bursts, in BURST:
  - `wb_bry_o` = read FIFO free slots ≥ 2, which covers one in-flight ack.
  - Each `wb_ack_i` pushes `wb_dat_i` and decrements `beat_cnt`.
- `wb_lack_i` sampled high → next cycle `wb_stb_o`=0, `wb_bry_o`=0, `done`=1, state IDLE.
- `wb_err_i` in BURST → drop `wb_stb_o`, pulse `err` with code 3, go to FLUSH. FLUSH empties the write FIFO in one cycle and returns to IDLE. Read FIFO contents are retained.
- An ack arriving while `beat_cnt`==0 is ignored and does not touch either FIFO.
- Simultaneous push and pop on either FIFO in the same cycle keeps the count unchanged. A push when full or a pop when empty is ignored.
- `wdata` may be pushed in any state except FLUSH, where `wdata_ready`=0.

## Timing
- Reset values: every registered output is 0, `wb_adr_o`/`wb_bl_o`/`wb_dat_o` are 0, `err_code`=0, both FIFOs are empty, `cmd_ready`=1.
- Command accepted at cycle T → `wb_stb_o` high at T+1, rejection `err` at T+1.
- Beat completion: exactly one beat per cycle in which `wb_ack_i`=1.
- Read data becomes visible on `rdata_valid` the cycle after its ack.
- `wb_lack_i` at cycle L → `wb_stb_o` low and `done` high at L+1. A new command can be accepted at L+1.
- Assertion of `rst_n` mid-burst clears state and FIFOs asynchronously. `wb_stb_o` drops immediately with no `done` or `err`.

## Test plan
- Write 4 beats to 0x2000 with the FIFO preloaded 0xA0..0xA3 → `wb_stb_o` at T+1, `wb_bl_o`=4, 4 acks pop in order, `done` one cycle after lack, FIFO empty.
- Read 8 beats from 0x3800 with `rdata_ready`=0 and `FIFO_DEPTH`=8 → `wb_bry_o` deasserts when free slots < 2; no read FIFO overflow. Then pull `rdata_ready`=1 → all 8 words delivered in order and `done` pulses once.
- Register write to 0x0004, `cmd_bl`=1, data 0x5A5A → single beat, `done`. Same address with `cmd_bl`=2 → `err`, code 1, no `wb_stb_o`.
- SRAM command at 0x27FC with `cmd_bl`=2 → `err`, code 2. Same address with `cmd_bl`=1 → accepted.
- Write burst of 6 beats with only 1 word queued → `wb_bry_o`=0 until 2 words are present. Assert `wb_err_i` mid-burst → `err` code 3, write FIFO flushed, back in IDLE.
- Assert `rst_n` low during a read burst → all outputs reach their reset values asynchronously; a fresh command completes normally afterwards.
